// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake FIFO: width helpers, DEPTH limits and
// the per-cycle occupancy operation encoding.
package handshake_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 256;

  // {push, pop} as seen by the occupancy counter
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/handshake_fifo_buffer_if.sv
// Valid/ready bundle carrying the upstream (ins) and downstream (outs) channels
// of the handshake FIFO; the buffer sits on the slave side.
interface handshake_fifo_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_fifo_mem.sv
// Storage array for the handshake FIFO: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ptr_width(DEPTH)-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [ptr_width(DEPTH)-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]          rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo_buffer.sv
// Valid/ready FIFO buffer with wrapping read/write pointers and an occupancy count.
// Define HANDSHAKE_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module handshake_fifo_buffer
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  handshake_fifo_buffer_if.slave      bus,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("handshake_fifo_buffer: DEPTH out of range");
  end

  logic                  active;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push;
  logic                  pop;
  logic                  pass_thru;
  fifo_op_e              op;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // active keeps ins_ready low during reset and until the first clock after release
  assign bus.ins_ready = active && (count != FULL_CNT);

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  logic empty;
  assign empty          = (count == '0);
  assign bus.outs_valid = active && (!empty || bus.ins_valid);
  assign bus.outs       = empty ? bus.ins : rd_data;
  assign pass_thru      = active && empty && bus.ins_valid && bus.outs_ready;
`else
  assign bus.outs_valid = (count != '0);
  assign bus.outs       = rd_data;
  assign pass_thru      = 1'b0;
`endif

  assign push = bus.ins_valid && bus.ins_ready && !pass_thru;
  assign pop  = bus.outs_valid && bus.outs_ready && (count != '0);
  assign op   = fifo_op_e'({push, pop});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      active <= 1'b1;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  handshake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.ins),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Scoreboard bench for handshake_fifo_buffer: a DEPTH=4 and a DEPTH=3 instance
// checked against a queue-based occupancy/order model.
module tb_handshake_fifo_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] sbq    [2][$];
  logic [31:0] outlog [2][$];
  int          mcnt   [2];

  handshake_fifo_buffer_if #(.DATA_WIDTH(32)) ifa ();
  handshake_fifo_buffer_if #(.DATA_WIDTH(32)) ifb ();

  handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) u_a (
    .clk (clk), .rst (rst), .bus (ifa.slave), .count (cnt_a)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u_b (
    .clk (clk), .rst (rst), .bus (ifb.slave), .count (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model step, evaluated mid-cycle when all handshake signals are settled
  task automatic mon(input int id, input int depth, input logic iv, input logic ir,
                     input logic [31:0] din, input logic ov, input logic ordy,
                     input logic [31:0] dout, input int cnt);
    bit push, pop, exp_ov;
    if (!mon_en) begin
      sbq[id].delete();
      mcnt[id] = 0;
      return;
    end
    chk($sformatf("count[%0d]", id), cnt, mcnt[id]);
    chk($sformatf("ins_ready[%0d]", id), {31'b0, ir}, {31'b0, mcnt[id] != depth});
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    exp_ov = (mcnt[id] != 0) || iv;
`else
    exp_ov = (mcnt[id] != 0);
`endif
    chk($sformatf("outs_valid[%0d]", id), {31'b0, ov}, {31'b0, exp_ov});
    push = iv && ir;
    pop  = ov && ordy;
    if (push) sbq[id].push_back(din);
    if (pop) begin
      outlog[id].push_back(dout);
      if (sbq[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow[%0d]: got %0h expected no token", id, dout);
      end else begin
        chk($sformatf("outs[%0d]", id), dout, sbq[id].pop_front());
      end
    end
    mcnt[id] = mcnt[id] + int'(push) - int'(pop);
  endtask

  always @(negedge clk) begin
    mon(0, 4, ifa.ins_valid, ifa.ins_ready, ifa.ins, ifa.outs_valid, ifa.outs_ready, ifa.outs, int'(cnt_a));
    mon(1, 3, ifb.ins_valid, ifb.ins_ready, ifb.ins, ifb.outs_valid, ifb.outs_ready, ifb.outs, int'(cnt_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] d);
    int n;
    ifa.ins = d;
    ifa.ins_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ifa.ins_ready) break;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got ins_ready=0 expected 1 within 50 cycles");
    end
    tick();
    ifa.ins_valid = 1'b0;
  endtask

  logic [31:0] exp_fill [4];
  logic [31:0] exp_sim  [3];

  initial begin
    int nxt, cyc, maxc;
    ifa.ins = '0; ifa.ins_valid = 1'b0; ifa.outs_ready = 1'b0;
    ifb.ins = '0; ifb.ins_valid = 1'b0; ifb.outs_ready = 1'b0;
    exp_fill = '{32'h0001E951, 32'h1, 32'h2, 32'h3};
    exp_sim  = '{32'h10, 32'h11, 32'hA};

    // Reset state
    #2;
    chk("rst_count_a", {29'b0, cnt_a}, 32'd0);
    chk("rst_ins_ready_a", {31'b0, ifa.ins_ready}, 32'd0);
    chk("rst_outs_valid_a", {31'b0, ifa.outs_valid}, 32'd0);
    chk("rst_ins_ready_b", {31'b0, ifb.ins_ready}, 32'd0);
    #21 rst = 1'b1;
    tick();
    chk("rel_ins_ready_a", {31'b0, ifa.ins_ready}, 32'd1);
    chk("rel_ins_ready_b", {31'b0, ifb.ins_ready}, 32'd1);
    mon_en = 1'b1;

    // Fill to full with outs_ready low
    for (int i = 0; i < 4; i++) push_a(exp_fill[i]);
    chk("full_count", {29'b0, cnt_a}, 32'd4);
    chk("full_ins_ready", {31'b0, ifa.ins_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("full_outs_hold", ifa.outs, 32'h0001E951);
      chk("full_outs_valid", {31'b0, ifa.outs_valid}, 32'd1);
      tick();
    end

    // Drain in order
    outlog[0].delete();
    ifa.outs_ready = 1'b1;
    repeat (4) tick();
    ifa.outs_ready = 1'b0;
    chk("drain_len", outlog[0].size(), 32'd4);
    for (int i = 0; i < 4 && i < outlog[0].size(); i++) chk("drain_order", outlog[0][i], exp_fill[i]);
    chk("drain_count", {29'b0, cnt_a}, 32'd0);
    chk("drain_outs_valid", {31'b0, ifa.outs_valid}, 32'd0);

    // Simultaneous push and pop at count 2
    push_a(32'h10);
    push_a(32'h11);
    chk("sim_pre_count", {29'b0, cnt_a}, 32'd2);
    outlog[0].delete();
    ifa.ins = 32'hA; ifa.ins_valid = 1'b1; ifa.outs_ready = 1'b1;
    tick();
    ifa.ins_valid = 1'b0; ifa.outs_ready = 1'b0;
    chk("sim_count", {29'b0, cnt_a}, 32'd2);
    ifa.outs_ready = 1'b1;
    repeat (2) tick();
    ifa.outs_ready = 1'b0;
    chk("sim_len", outlog[0].size(), 32'd3);
    for (int i = 0; i < 3 && i < outlog[0].size(); i++) chk("sim_order", outlog[0][i], exp_sim[i]);

    // Latency from an empty buffer
    tick();
    ifa.outs_ready = 1'b1;
    ifa.ins = 32'h0001E951; ifa.ins_valid = 1'b1;
    #1;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    chk("lat_outs_valid_now", {31'b0, ifa.outs_valid}, 32'd1);
    chk("lat_outs_now", ifa.outs, 32'h0001E951);
    tick();
    ifa.ins_valid = 1'b0;
    chk("lat_count", {29'b0, cnt_a}, 32'd0);
    chk("lat_outs_valid_after", {31'b0, ifa.outs_valid}, 32'd0);
`else
    chk("lat_outs_valid_now", {31'b0, ifa.outs_valid}, 32'd0);
    tick();
    ifa.ins_valid = 1'b0;
    chk("lat_count", {29'b0, cnt_a}, 32'd1);
    chk("lat_outs_valid_after", {31'b0, ifa.outs_valid}, 32'd1);
    chk("lat_outs_after", ifa.outs, 32'h0001E951);
    tick();
`endif
    ifa.outs_ready = 1'b0;
    tick();

    // Reset asserted mid-stream with three tokens held
    for (int i = 0; i < 3; i++) push_a(32'h100 + i);
    chk("mid_pre_count", {29'b0, cnt_a}, 32'd3);
    #2;
    rst = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("mid_count", {29'b0, cnt_a}, 32'd0);
    chk("mid_outs_valid", {31'b0, ifa.outs_valid}, 32'd0);
    chk("mid_ins_ready", {31'b0, ifa.ins_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk("mid_rel_ins_ready", {31'b0, ifa.ins_ready}, 32'd1);
    chk("mid_rel_count", {29'b0, cnt_a}, 32'd0);
    mon_en = 1'b1;
    ifa.outs_ready = 1'b1;
    repeat (4) tick();
    ifa.outs_ready = 1'b0;

    // Randomized traffic on the DEPTH=4 instance
    for (int i = 0; i < 300; i++) begin
      ifa.ins_valid  = $urandom_range(0, 1) == 1;
      ifa.ins        = $urandom;
      ifa.outs_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    ifa.ins_valid = 1'b0;
    ifa.outs_ready = 1'b1;
    repeat (6) tick();
    ifa.outs_ready = 1'b0;
    chk("rand_drained", sbq[0].size(), 32'd0);
    chk("rand_count", {29'b0, cnt_a}, 32'd0);

    // Wrap-around on the DEPTH=3 instance with tokens 0..9
    outlog[1].delete();
    nxt = 0; cyc = 0; maxc = 0;
    while (outlog[1].size() < 10 && cyc < 500) begin
      ifb.ins_valid  = (nxt < 10) && ($urandom_range(0, 1) == 1);
      ifb.ins        = 32'(nxt);
      ifb.outs_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (ifb.ins_valid && ifb.ins_ready) nxt++;
      if (int'(cnt_b) > maxc) maxc = int'(cnt_b);
      tick();
      cyc++;
    end
    ifb.ins_valid = 1'b0;
    ifb.outs_ready = 1'b0;
    chk("wrap_len", outlog[1].size(), 32'd10);
    for (int i = 0; i < 10 && i < outlog[1].size(); i++) chk("wrap_order", outlog[1][i], 32'(i));
    chk("wrap_max_le3", {31'b0, maxc <= 3}, 32'd1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_buffer.md
HANDSHAKE_FIFO_BUFFER -- requirements
Module: handshake_fifo_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the number of storage slots; legal range 2..256.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-low reset, asserted at 0.
REQ-005 SHALL have port ins, input, DATA_WIDTH, the upstream payload (for example a constant-generator output).
REQ-006 SHALL have port ins_valid, input, 1, the upstream valid.
REQ-007 SHALL have port ins_ready, output, 1, the ready returned upstream.
REQ-008 SHALL have port outs, output, DATA_WIDTH, the downstream payload.
REQ-009 SHALL have port outs_valid, output, 1, the downstream valid.
REQ-010 SHALL have port outs_ready, input, 1, the downstream ready.
REQ-011 SHALL have port count, output, CW, the current occupancy, where CW = clog2(DEPTH+1).

Function
REQ-012 SHALL accept a token on a cycle where ins_valid and ins_ready are both 1 (push), and SHALL release one on a cycle where outs_valid and outs_ready are both 1 (pop).
REQ-013 SHALL drive ins_ready = (count != DEPTH), with no combinational dependence on outs_ready; a push while full is impossible.
REQ-014 SHALL deliver tokens strictly FIFO, with no loss and no duplication.
REQ-015 SHALL keep outs stable and outs_valid high while outs_valid=1 and outs_ready=0.
REQ-016 SHALL use a write pointer and a read pointer, each wrapping from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-017 SHALL, on a simultaneous push and pop with 0<count<DEPTH, leave count unchanged and advance both pointers.
REQ-018 SHALL update count +1 on push only, -1 on pop only, and leave it unchanged otherwise.
REQ-019 SHALL, without bypass, give outs_valid = (count != 0), outs = the slot at the read pointer, and a push-to-outs_valid latency of 1 cycle.
REQ-020 SHALL hold slots that are not occupied stale; their content is don't-care.

Reset
REQ-021 SHALL, while rst=0, force count=0, both pointers=0, ins_ready=0 and outs_valid=0, asynchronously.
REQ-022 SHALL release reset synchronously; from the first rising edge with rst=1, ins_ready=1 and the buffer is empty.
REQ-023 SHALL discard all buffered tokens on a reset asserted mid-operation; no token appears after release.
REQ-024 SHALL not reset the storage array.

Configuration
REQ-025 SHALL recognise macro HANDSHAKE_FIFO_BYPASS_EN.
REQ-026 SHALL, when HANDSHAKE_FIFO_BYPASS_EN is defined and count==0:
- drive outs_valid = ins_valid and outs = ins combinationally;
- when outs_ready=1, pass the token through with no write and no count change (zero latency);
- when outs_ready=0, write the token normally.
REQ-027 SHALL, when HANDSHAKE_FIFO_BYPASS_EN is undefined, contain no combinational path from ins or ins_valid to outs or outs_valid.

Structure
REQ-028 SHALL take the following from shared package handshake_pkg:
- the clog2-based pointer and count width function;
- the DEPTH legality constants (DEPTH_MIN=2, DEPTH_MAX=256).
REQ-029 SHALL place storage in sub-module handshake_fifo_mem (DEPTH x DATA_WIDTH, one write port, one asynchronous read port); control stays in handshake_fifo_buffer.

Verification
REQ-030 SHALL cover a reset check: DEPTH=4, rst=0 mid-stream with count=3 -> count=0, outs_valid=0, ins_ready=0 immediately; one cycle after release, ins_ready=1.
REQ-031 SHALL cover fill to full: DEPTH=4, outs_ready=0, push 32'h0001E951, 32'h1, 32'h2, 32'h3 -> count=4, ins_ready=0, outs=32'h0001E951 held stable.
REQ-032 SHALL cover drain in order: from the full state, outs_ready=1 for 4 cycles -> outs sequence 32'h0001E951, 1, 2, 3, then count=0 and outs_valid=0.
REQ-033 SHALL cover wrap-around: DEPTH=3, 10 tokens 0..9 with random ins_valid/outs_ready -> output exactly 0..9 in order, count never exceeds 3.
REQ-034 SHALL cover simultaneous push and pop: count=2, push 32'hA while popping -> count stays 2, pointers each advance by 1.
REQ-035 SHALL cover latency: empty buffer, single push of 32'h0001E951, outs_ready=1 -> outs_valid in the same cycle with HANDSHAKE_FIFO_BYPASS_EN and count stays 0; one cycle later without it.
